mem_port_requester: RTL and testbench
=====================================

Name: mem_port_requester

Overview:
- Initiator side of the multiport memory interface.
- Accepts valid/ready read and write requests from N_CLIENTS clients and allocates them each cycle onto the memory's read and write ports, round-robin.
- Captures read data one cycle after issue and returns it through per-client response registers with backpressure.
- Sits between the core-side clients (fetch, load/store, debug) and the memory.

Parameters:
WIDTH, 32, data width; equals the memory WIDTH
N, 4, memory depth; AW = $clog2(N)
N_READ_PORTS, 2, memory read ports driven
N_WRITE_PORTS, 1, memory write ports driven
N_CLIENTS, 3, request/response clients

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
req_valid  in  [N_CLIENTS]  client request valid
req_ready  out  [N_CLIENTS]  request granted this cycle
req_we  in  [N_CLIENTS]  1=write, 0=read
req_adr  in  [AW] x N_CLIENTS  address
req_wdata  in  [WIDTH] x N_CLIENTS  write data
rsp_valid  out  [N_CLIENTS]  read data available
rsp_ready  in  [N_CLIENTS]  client accepts response
rsp_data  out  [WIDTH] x N_CLIENTS  read data
mem_read_en  out  [N_READ_PORTS]  memory read enables
mem_read_adr  out  [AW] x N_READ_PORTS  memory read addresses
mem_write_en  out  [N_WRITE_PORTS]  memory write enables
mem_write_adr  out  [AW] x N_WRITE_PORTS  memory write addresses
mem_data_in  out  [WIDTH] x N_WRITE_PORTS  memory write data
mem_data_out  in  [WIDTH] x N_READ_PORTS  memory read data, valid the cycle after mem_read_en

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - rsp_valid=0, rsp_data=0, inflight=0, rr_ptr=0.
  - req_ready, mem_read_en and mem_write_en are forced to 0 while reset is high (they are combinational outputs).
- Eligibility:
  - Write: req_valid & req_we.
  - Read: req_valid & !req_we & !inflight[i] & !(rsp_valid[i] & !rsp_ready[i]).
- Allocation (combinational each cycle):
  - Scan clients starting at rr_ptr, wrapping modulo N_CLIENTS.
  - The k-th eligible reader gets read port k; the k-th eligible writer gets write port k.
  - Allocation stops per type when that type's ports are exhausted.
  - req_ready[i]=1 only if client i got a port. Unused ports have their enable low; their addr/data are don't-care and driven 0.
- rr_ptr update: becomes (last granted client + 1) mod N_CLIENTS. If nothing is granted, it is unchanged.
- Read pipeline, grant at cycle t:
  - At the edge ending t, set inflight[i] and record the port index.
  - During t+1, mem_data_out[port] is valid. At the edge ending t+1, rsp_data[i] <= mem_data_out[port], rsp_valid[i] <= 1, inflight[i] cleared.
  - rsp_valid rises in cycle t+2, i.e. request-to-response latency is 2.
  - A client gets at most one read per 2 cycles.
- Response: rsp_valid[i] and rsp_data[i] hold stable until rsp_ready[i]. The slot clears on rsp_valid & rsp_ready.
- Writes: fire-and-forget, no response; complete in the memory at the edge ending the grant cycle.
- Same-address write and read in one cycle: the read returns the old memory contents (the memory reads before it writes).
- Multiple writes to one address in one cycle: the highest write port index wins, i.e. the later client in rr order.
- Reset mid-operation: in-flight reads and pending responses are discarded; no rsp_valid is generated for them.

Optional Feature:
- Macro: MEM_REQ_BYPASS_EN.
- Defined: on a same-cycle read/write address match, the granted read captures the matching write data at grant (highest write port on multiple matches) and returns it instead of mem_data_out. Latency is unchanged.
- Undefined: old-data behaviour as above.

Decomposition:
- Package mem_req_pkg:
  - constant MEM_RSP_LATENCY = 2;
  - function rr_next(last_grant, n);
  - enum req_kind_e {REQ_READ, REQ_WRITE}.
- Sub-module rr_port_allocator: combinational; inputs are the eligibility vector and rr_ptr; outputs are port-to-client maps and grant vectors. Instantiated once for reads and once for writes.

Test Plan:
- Client0 writes adr 2 = 0xDEADBEEF; a cycle later it reads adr 2 → req_ready the same cycle as valid; rsp_valid[0] 2 cycles later with rsp_data 0xDEADBEEF.
- Clients 0, 1 and 2 all read with rr_ptr=0 and 2 read ports → clients 0 and 1 granted and rr_ptr=2. Next cycle client 2 is granted before 0/1.
- Client1 holds rsp_ready=0 with a response pending and keeps requesting reads → no grant to client1 until rsp_ready=1. rsp_data stays stable throughout.
- Same cycle, client0 writes adr 1 = 0x5 and client1 reads adr 1 (old value 0x0) → response 0x0. With MEM_REQ_BYPASS_EN the response is 0x5.
- Reset asserted the cycle after a read grant → no rsp_valid ever appears for it, and all grants drop immediately. After deassert, rr_ptr=0.
- Two writers to adr 3 with 2 write ports, rr order c1 then c2 → a subsequent read of adr 3 returns c2's data.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared constants, request kinds and the round-robin pointer helper for the memory port requester.
package mem_req_pkg;

  localparam int MEM_RSP_LATENCY = 2;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  function automatic int rr_next(input int last_grant, input int n);
    return (last_grant + 1 >= n) ? 0 : last_grant + 1;
  endfunction

endpackage

// File: rtl/mem_port_requester_rr_port_allocator.sv
// Combinational round-robin allocator: the k-th eligible client, scanning from rr_ptr, gets port k.
module rr_port_allocator #(
  parameter int N_CLIENTS = 3,
  parameter int N_PORTS   = 2,
  parameter int CW        = 2
) (
  input  logic [N_CLIENTS-1:0]         elig,
  input  logic [CW-1:0]                rr_ptr,
  output logic [N_PORTS-1:0]           port_en,
  output logic [N_PORTS-1:0][CW-1:0]   port_client,
  output logic [N_CLIENTS-1:0]         grant
);

  int pos  [N_CLIENTS];
  int rank [N_CLIENTS];

  // pos = distance from rr_ptr in scan order; rank = eligible clients scanned before this one
  always_comb begin
    grant       = '0;
    port_en     = '0;
    port_client = '0;
    for (int c = 0; c < N_CLIENTS; c++) begin
      pos[c] = c - int'(rr_ptr);
      if (pos[c] < 0) pos[c] = pos[c] + N_CLIENTS;
    end
    for (int c = 0; c < N_CLIENTS; c++) begin
      rank[c] = 0;
      for (int c2 = 0; c2 < N_CLIENTS; c2++) begin
        if (elig[c2] && (pos[c2] < pos[c])) rank[c] = rank[c] + 1;
      end
    end
    for (int c = 0; c < N_CLIENTS; c++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (elig[c] && (rank[c] == p)) begin
          grant[c]       = 1'b1;
          port_en[p]     = 1'b1;
          port_client[p] = CW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_requester.sv
// Round-robin requester: maps client read/write requests onto memory ports and returns read data.
// Build option: define MEM_REQ_BYPASS_EN to forward same-cycle write data to a matching read.
module mem_port_requester
  import mem_req_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int N             = 4,
  parameter int N_READ_PORTS  = 2,
  parameter int N_WRITE_PORTS = 1,
  parameter int N_CLIENTS     = 3,
  localparam int AW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CLIENTS-1:0]                   req_valid,
  output logic [N_CLIENTS-1:0]                   req_ready,
  input  logic [N_CLIENTS-1:0]                   req_we,
  input  logic [N_CLIENTS-1:0][AW-1:0]           req_adr,
  input  logic [N_CLIENTS-1:0][WIDTH-1:0]        req_wdata,
  output logic [N_CLIENTS-1:0]                   rsp_valid,
  input  logic [N_CLIENTS-1:0]                   rsp_ready,
  output logic [N_CLIENTS-1:0][WIDTH-1:0]        rsp_data,
  output logic [N_READ_PORTS-1:0]                mem_read_en,
  output logic [N_READ_PORTS-1:0][AW-1:0]        mem_read_adr,
  output logic [N_WRITE_PORTS-1:0]               mem_write_en,
  output logic [N_WRITE_PORTS-1:0][AW-1:0]       mem_write_adr,
  output logic [N_WRITE_PORTS-1:0][WIDTH-1:0]    mem_data_in,
  input  logic [N_READ_PORTS-1:0][WIDTH-1:0]     mem_data_out
);

  localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int PW = (N_READ_PORTS > 1) ? $clog2(N_READ_PORTS) : 1;

  // Handshake: a request transfers in the cycle req_valid & req_ready; a response
  // transfers in the cycle rsp_valid & rsp_ready and stays stable until then.

  logic [N_CLIENTS-1:0]                rd_elig, wr_elig, rd_grant, wr_grant;
  logic [N_READ_PORTS-1:0]             rd_port_en;
  logic [N_READ_PORTS-1:0][CW-1:0]     rd_port_client;
  logic [N_WRITE_PORTS-1:0]            wr_port_en;
  logic [N_WRITE_PORTS-1:0][CW-1:0]    wr_port_client;

  logic [CW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [N_CLIENTS-1:0]                inflight_q, inflight_d;
  logic [N_CLIENTS-1:0][PW-1:0]        rd_port_q, rd_port_d;
  logic [N_CLIENTS-1:0]                rsp_valid_q, rsp_valid_d;
  logic [N_CLIENTS-1:0][WIDTH-1:0]     rsp_data_q, rsp_data_d;
`ifdef MEM_REQ_BYPASS_EN
  logic [N_CLIENTS-1:0]                byp_hit_q, byp_hit_d;
  logic [N_CLIENTS-1:0][WIDTH-1:0]     byp_data_q, byp_data_d;
`endif

  int rr_pos;
  int rr_best;

  // Reset gates eligibility so every grant and memory enable drops at once.
  always_comb begin
    for (int c = 0; c < N_CLIENTS; c++) begin
      wr_elig[c] = !reset && req_valid[c] && (req_kind_e'(req_we[c]) == REQ_WRITE);
      rd_elig[c] = !reset && req_valid[c] && (req_kind_e'(req_we[c]) == REQ_READ) &&
                   !inflight_q[c] && !(rsp_valid_q[c] && !rsp_ready[c]);
    end
  end

  rr_port_allocator #(.N_CLIENTS(N_CLIENTS), .N_PORTS(N_READ_PORTS), .CW(CW)) u_rd_alloc (
    .elig        (rd_elig),
    .rr_ptr      (rr_ptr_q),
    .port_en     (rd_port_en),
    .port_client (rd_port_client),
    .grant       (rd_grant)
  );

  rr_port_allocator #(.N_CLIENTS(N_CLIENTS), .N_PORTS(N_WRITE_PORTS), .CW(CW)) u_wr_alloc (
    .elig        (wr_elig),
    .rr_ptr      (rr_ptr_q),
    .port_en     (wr_port_en),
    .port_client (wr_port_client),
    .grant       (wr_grant)
  );

  assign req_ready    = rd_grant | wr_grant;
  assign mem_read_en  = rd_port_en;
  assign mem_write_en = wr_port_en;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

  always_comb begin
    mem_read_adr  = '0;
    mem_write_adr = '0;
    mem_data_in   = '0;
    for (int p = 0; p < N_READ_PORTS; p++) begin
      for (int c = 0; c < N_CLIENTS; c++) begin
        if (rd_port_en[p] && (rd_port_client[p] == CW'(c))) mem_read_adr[p] = req_adr[c];
      end
    end
    for (int w = 0; w < N_WRITE_PORTS; w++) begin
      for (int c = 0; c < N_CLIENTS; c++) begin
        if (wr_port_en[w] && (wr_port_client[w] == CW'(c))) begin
          mem_write_adr[w] = req_adr[c];
          mem_data_in[w]   = req_wdata[c];
        end
      end
    end
  end

  // The pointer moves past whichever granted client (read or write) sits last in scan order.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rr_best  = -1;
    rr_pos   = 0;
    for (int c = 0; c < N_CLIENTS; c++) begin
      rr_pos = c - int'(rr_ptr_q);
      if (rr_pos < 0) rr_pos = rr_pos + N_CLIENTS;
      if (req_ready[c] && (rr_pos > rr_best)) begin
        rr_best  = rr_pos;
        rr_ptr_d = CW'(rr_next(c, N_CLIENTS));
      end
    end
  end

  // A granted client is ineligible while in flight, so inflight lasts exactly one cycle.
  always_comb begin
    inflight_d = rd_grant;
    rd_port_d  = rd_port_q;
    for (int c = 0; c < N_CLIENTS; c++) begin
      for (int p = 0; p < N_READ_PORTS; p++) begin
        if (rd_port_en[p] && (rd_port_client[p] == CW'(c))) rd_port_d[c] = PW'(p);
      end
    end
  end

`ifdef MEM_REQ_BYPASS_EN
  // Ascending port order lets the highest matching write port win.
  always_comb begin
    byp_hit_d  = '0;
    byp_data_d = '0;
    for (int c = 0; c < N_CLIENTS; c++) begin
      for (int w = 0; w < N_WRITE_PORTS; w++) begin
        if (rd_grant[c] && wr_port_en[w] && (mem_write_adr[w] == req_adr[c])) begin
          byp_hit_d[c]  = 1'b1;
          byp_data_d[c] = mem_data_in[w];
        end
      end
    end
  end
`endif

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int c = 0; c < N_CLIENTS; c++) begin
      if (rsp_valid_q[c] && rsp_ready[c]) rsp_valid_d[c] = 1'b0;
      if (inflight_q[c]) begin
        rsp_valid_d[c] = 1'b1;
        for (int p = 0; p < N_READ_PORTS; p++) begin
          if (rd_port_q[c] == PW'(p)) rsp_data_d[c] = mem_data_out[p];
        end
`ifdef MEM_REQ_BYPASS_EN
        if (byp_hit_q[c]) rsp_data_d[c] = byp_data_q[c];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
      rd_port_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef MEM_REQ_BYPASS_EN
      byp_hit_q   <= '0;
      byp_data_q  <= '0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      rd_port_q   <= rd_port_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef MEM_REQ_BYPASS_EN
      byp_hit_q   <= byp_hit_d;
      byp_data_q  <= byp_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_requester.sv
// Bench for mem_port_requester: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_requester;
  import mem_req_pkg::*;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int NRP = 2;
  localparam int NWP = 2;
  localparam int NC  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NC-1:0]           req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [NC-1:0][AW-1:0]   req_adr;
  logic [NC-1:0][W-1:0]    req_wdata, rsp_data;
  logic [NRP-1:0]          mem_read_en;
  logic [NRP-1:0][AW-1:0]  mem_read_adr;
  logic [NWP-1:0]          mem_write_en;
  logic [NWP-1:0][AW-1:0]  mem_write_adr;
  logic [NWP-1:0][W-1:0]   mem_data_in;
  logic [NRP-1:0][W-1:0]   mem_data_out;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_requester #(
    .WIDTH(W), .N(N), .N_READ_PORTS(NRP), .N_WRITE_PORTS(NWP), .N_CLIENTS(NC)
  ) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_read_en(mem_read_en), .mem_read_adr(mem_read_adr),
    .mem_write_en(mem_write_en), .mem_write_adr(mem_write_adr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // clock / memory
  always #5 clk = ~clk;

  logic [W-1:0] mem [N];
  always @(posedge clk) begin
    for (int p = 0; p < NRP; p++) if (mem_read_en[p]) mem_data_out[p] <= mem[mem_read_adr[p]];
    for (int w = 0; w < NWP; w++) if (mem_write_en[w]) mem[mem_write_adr[w]] <= mem_data_in[w];
  end

  // reference model state
  typedef struct { int c; logic [W-1:0] d; int due; } pend_t;
  pend_t               pend_q[$];
  logic [W-1:0]        ref_mem [N];
  int                  m_rr;
  int                  m_cyc;
  logic [NC-1:0]       m_rv;
  logic [NC-1:0][W-1:0] m_rd;

  logic [NC-1:0]        exp_ready, exp_rv;
  logic [NC-1:0][W-1:0] exp_rd;
  logic [NRP-1:0]       exp_rd_en;
  logic [NWP-1:0]       exp_wr_en;
  logic [AW-1:0]        exp_rd_adr[$];
  logic [AW-1:0]        exp_wr_adr[$];
  logic [W-1:0]         exp_wr_dat[$];

  task automatic model_step();
    int last, nr, nw, c;
    bit busy;
    logic [W-1:0] d;
    int rd_l[$];
    int wr_l[$];
    pend_t e;
    exp_rd_adr.delete(); exp_wr_adr.delete(); exp_wr_dat.delete();
    if (rst) begin
      exp_ready = '0; exp_rd_en = '0; exp_wr_en = '0; exp_rv = '0; exp_rd = '0;
      m_rr = 0; m_rv = '0; m_rd = '0; pend_q.delete();
      return;
    end
    exp_rv = m_rv; exp_rd = m_rd; exp_ready = '0;
    nr = 0; nw = 0; last = -1;
    for (int s = 0; s < NC; s++) begin
      c = (m_rr + s) % NC;
      busy = 1'b0;
      foreach (pend_q[k]) if (pend_q[k].c == c) busy = 1'b1;
      if (req_valid[c] && !req_we[c] && !busy && !(m_rv[c] && !rsp_ready[c]) && nr < NRP) begin
        nr++; rd_l.push_back(c); exp_rd_adr.push_back(req_adr[c]);
        exp_ready[c] = 1'b1; last = c;
      end
      if (req_valid[c] && req_we[c] && nw < NWP) begin
        nw++; wr_l.push_back(c); exp_wr_adr.push_back(req_adr[c]); exp_wr_dat.push_back(req_wdata[c]);
        exp_ready[c] = 1'b1; last = c;
      end
    end
    exp_rd_en = NRP'((1 << nr) - 1);
    exp_wr_en = NWP'((1 << nw) - 1);
    for (int i = 0; i < NC; i++) if (m_rv[i] && rsp_ready[i]) m_rv[i] = 1'b0;
    while (pend_q.size() > 0 && pend_q[0].due == m_cyc) begin
      e = pend_q.pop_front();
      m_rv[e.c] = 1'b1; m_rd[e.c] = e.d;
    end
    foreach (rd_l[i]) begin
      d = ref_mem[req_adr[rd_l[i]]];
`ifdef MEM_REQ_BYPASS_EN
      foreach (wr_l[j]) if (req_adr[wr_l[j]] == req_adr[rd_l[i]]) d = req_wdata[wr_l[j]];
`endif
      e.c = rd_l[i]; e.d = d; e.due = m_cyc + MEM_RSP_LATENCY - 1;
      pend_q.push_back(e);
    end
    foreach (wr_l[j]) ref_mem[req_adr[wr_l[j]]] = req_wdata[wr_l[j]];
    if (last >= 0) m_rr = (last + 1) % NC;
    m_cyc++;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic eval();
    @(negedge clk);
    model_step();
  endtask

  task automatic set_idle();
    req_valid = '0; req_we = '0; req_adr = '0; req_wdata = '0;
  endtask

  task automatic pulse_reset();
    tick(); rst = 1'b1; set_idle(); eval();
    tick(); rst = 1'b0; eval();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin tick(); set_idle(); eval(); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_we = '0; req_adr = '0; req_wdata = '0; rsp_ready = '1;
    eval();
    n_checks++; if (req_ready !== '0) begin n_errors++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
    n_checks++; if (mem_read_en !== '0 || mem_write_en !== '0) begin n_errors++; $display("FAIL rst_mem_en got=%b/%b exp=00/00", mem_read_en, mem_write_en); end
    n_checks++; if (rsp_valid !== '0 || rsp_data !== '0) begin n_errors++; $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_valid, rsp_data); end
    tick(); rst = 1'b0; set_idle(); eval();
    n_checks++; if (rsp_valid !== '0) begin n_errors++; $display("FAIL rst_release_rsp got=%b exp=000", rsp_valid); end
  endtask

  task automatic test_write_then_read();
    tick(); set_idle(); req_valid = 3'b001; req_we = 3'b001; req_adr[0] = 2'd2; req_wdata[0] = 32'hDEADBEEF; eval();
    n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL wr_ready got=%b exp=001", req_ready); end
    n_checks++; if (mem_write_en !== 2'b01 || mem_write_adr[0] !== 2'd2 || mem_data_in[0] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL wr_port got=%b/%0d/%h exp=01/2/deadbeef", mem_write_en, mem_write_adr[0], mem_data_in[0]); end
    tick(); req_we = 3'b000; eval();
    n_checks++; if (req_ready !== 3'b001 || mem_read_en !== 2'b01 || mem_read_adr[0] !== 2'd2) begin
      n_errors++; $display("FAIL rd_grant got=%b/%b/%0d exp=001/01/2", req_ready, mem_read_en, mem_read_adr[0]); end
    tick(); set_idle(); eval();
    n_checks++; if (rsp_valid[0] !== 1'b0) begin n_errors++; $display("FAIL rd_early got=%b exp=0", rsp_valid[0]); end
    tick(); eval();
    n_checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL rd_rsp got=%b/%h exp=1/deadbeef", rsp_valid[0], rsp_data[0]); end
    idle_cycles(2);
  endtask

  task automatic test_rr_reads();
    pulse_reset();
    tick(); req_valid = 3'b111; req_we = '0; req_adr[0] = 2'd0; req_adr[1] = 2'd1; req_adr[2] = 2'd2; eval();
    n_checks++; if (req_ready !== 3'b011) begin n_errors++; $display("FAIL rr_first got=%b exp=011", req_ready); end
    tick(); eval();
    n_checks++; if (req_ready !== 3'b100 || mem_read_adr[0] !== 2'd2) begin
      n_errors++; $display("FAIL rr_second got=%b/%0d exp=100/2", req_ready, mem_read_adr[0]); end
    tick(); set_idle(); eval();
    n_checks++; if (rsp_valid !== 3'b011 || rsp_data[0] !== 32'h0 || rsp_data[1] !== 32'h0) begin
      n_errors++; $display("FAIL rr_rsp01 got=%b/%h/%h exp=011/0/0", rsp_valid, rsp_data[0], rsp_data[1]); end
    tick(); eval();
    n_checks++; if (rsp_valid !== 3'b100 || rsp_data[2] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL rr_rsp2 got=%b/%h exp=100/deadbeef", rsp_valid, rsp_data[2]); end
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    tick(); set_idle(); rsp_ready = 3'b101; req_valid = 3'b010; req_adr[1] = 2'd2; eval();
    n_checks++; if (req_ready !== 3'b010) begin n_errors++; $display("FAIL bp_grant got=%b exp=010", req_ready); end
    tick(); eval();
    n_checks++; if (req_ready !== 3'b000) begin n_errors++; $display("FAIL bp_inflight got=%b exp=000", req_ready); end
    for (int i = 0; i < 5; i++) begin
      tick(); eval();
      n_checks++; if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'hDEADBEEF) begin
        n_errors++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=0/1/deadbeef", i, req_ready[1], rsp_valid[1], rsp_data[1]); end
    end
    tick(); rsp_ready = 3'b111; eval();
    n_checks++; if (req_ready[1] !== 1'b1) begin n_errors++; $display("FAIL bp_release got=%b exp=1", req_ready[1]); end
    idle_cycles(3);
  endtask

  task automatic test_same_cycle_rw();
    logic [W-1:0] want;
`ifdef MEM_REQ_BYPASS_EN
    want = 32'h5;
`else
    want = 32'h0;
`endif
    tick(); set_idle(); req_valid = 3'b011; req_we = 3'b001; req_adr[0] = 2'd1; req_wdata[0] = 32'h5; req_adr[1] = 2'd1; eval();
    n_checks++; if (req_ready !== 3'b011) begin n_errors++; $display("FAIL rw_grant got=%b exp=011", req_ready); end
    idle_cycles(1);
    tick(); eval();
    n_checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== want) begin
      n_errors++; $display("FAIL rw_data got=%b/%h exp=1/%h", rsp_valid[1], rsp_data[1], want); end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    tick(); set_idle(); req_valid = 3'b100; req_adr[2] = 2'd1; eval();
    n_checks++; if (req_ready !== 3'b100) begin n_errors++; $display("FAIL rm_grant got=%b exp=100", req_ready); end
    tick(); rst = 1'b1; req_valid = 3'b111; eval();
    n_checks++; if (req_ready !== '0 || mem_read_en !== '0) begin n_errors++; $display("FAIL rm_drop got=%b/%b exp=000/00", req_ready, mem_read_en); end
    tick(); rst = 1'b0; set_idle(); eval();
    n_checks++; if (rsp_valid !== '0) begin n_errors++; $display("FAIL rm_rsp0 got=%b exp=000", rsp_valid); end
    tick(); eval();
    n_checks++; if (rsp_valid !== '0) begin n_errors++; $display("FAIL rm_rsp1 got=%b exp=000", rsp_valid); end
    tick(); req_valid = 3'b111; req_we = '0; eval();
    n_checks++; if (req_ready !== 3'b011) begin n_errors++; $display("FAIL rm_rrptr got=%b exp=011", req_ready); end
    idle_cycles(3);
  endtask

  task automatic test_dual_write();
    pulse_reset();
    tick(); set_idle(); req_valid = 3'b110; req_we = 3'b110; req_adr[1] = 2'd3; req_adr[2] = 2'd3;
    req_wdata[1] = 32'hAAAA1111; req_wdata[2] = 32'hBBBB2222; eval();
    n_checks++; if (req_ready !== 3'b110 || mem_write_en !== 2'b11) begin
      n_errors++; $display("FAIL dw_grant got=%b/%b exp=110/11", req_ready, mem_write_en); end
    tick(); set_idle(); req_valid = 3'b001; req_adr[0] = 2'd3; eval();
    idle_cycles(1);
    tick(); eval();
    n_checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hBBBB2222) begin
      n_errors++; $display("FAIL dw_data got=%b/%h exp=1/bbbb2222", rsp_valid[0], rsp_data[0]); end
    idle_cycles(2);
  endtask

  task automatic test_random();
    pulse_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NC; c++) begin
        req_valid[c] = ($urandom_range(0, 9) < 7);
        req_we[c]    = $urandom_range(0, 1);
        req_adr[c]   = AW'($urandom_range(0, N - 1));
        req_wdata[c] = $urandom;
        rsp_ready[c] = ($urandom_range(0, 3) != 0);
      end
      eval();
      n_checks++; if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      n_checks++; if (mem_read_en !== exp_rd_en || mem_write_en !== exp_wr_en) begin
        n_errors++; $display("FAIL rnd_en cyc=%0d got=%b/%b exp=%b/%b", cyc, mem_read_en, mem_write_en, exp_rd_en, exp_wr_en); end
      for (int p = 0; p < NRP; p++) if (p < exp_rd_adr.size()) begin
        n_checks++; if (mem_read_adr[p] !== exp_rd_adr[p]) begin
          n_errors++; $display("FAIL rnd_radr cyc=%0d port=%0d got=%0d exp=%0d", cyc, p, mem_read_adr[p], exp_rd_adr[p]); end
      end
      for (int w = 0; w < NWP; w++) if (w < exp_wr_adr.size()) begin
        n_checks++; if (mem_write_adr[w] !== exp_wr_adr[w] || mem_data_in[w] !== exp_wr_dat[w]) begin
          n_errors++; $display("FAIL rnd_wport cyc=%0d port=%0d got=%0d/%h exp=%0d/%h", cyc, w, mem_write_adr[w], mem_data_in[w], exp_wr_adr[w], exp_wr_dat[w]); end
      end
      n_checks++; if (rsp_valid !== exp_rv) begin n_errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end
      for (int c = 0; c < NC; c++) if (exp_rv[c]) begin
        n_checks++; if (rsp_data[c] !== exp_rd[c]) begin
          n_errors++; $display("FAIL rnd_rdata cyc=%0d client=%0d got=%h exp=%h", cyc, c, rsp_data[c], exp_rd[c]); end
      end
    end
    rst = 1'b0;
    rsp_ready = '1;
    idle_cycles(3);
  endtask

  initial begin
    for (int a = 0; a < N; a++) begin mem[a] = '0; ref_mem[a] = '0; end
    mem_data_out = '0;
    m_rr = 0; m_cyc = 0; m_rv = '0; m_rd = '0;
    test_reset();
    test_write_then_read();
    test_rr_reads();
    test_backpressure();
    test_same_cycle_rw();
    test_reset_mid();
    test_dual_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
